// File: rtl/cpu_phase_ctl.sv
// Four-phase (F/E/M/W) sequencer and run controller for the cpu2 core, with wait
// states, halt/run/single-step, a PC breakpoint, wait timeout and debug counters.
module cpu_phase_ctl #(
   parameter int WIDTH     = 32,
   parameter int WAIT_MAX  = 15,
   parameter int START_RUN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic             mem_wait,
   input  logic             bp_en,
   input  logic [WIDTH-1:0] bp_addr,
   input  logic [WIDTH-1:0] pc,
   output logic             st_f,
   output logic             st_e,
   output logic             st_m,
   output logic             st_w,
   output logic             phf,
   output logic             phe,
   output logic             phm,
   output logic             phw,
   output logic             halted,
   output logic             bp_hit,
   output logic             bus_err,
   output logic [2:0]       clk_stat,
   output logic [WIDTH-1:0] cyc_cnt,
   output logic [WIDTH-1:0] ins_cnt
);

   typedef enum logic [2:0] {
      S_HALT = 3'd0,
      S_F    = 3'd1,
      S_E    = 3'd2,
      S_M    = 3'd3,
      S_W    = 3'd4
   } state_t;

   localparam int            CW   = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

   state_t           state_q, state_d;
   logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
   logic             step_mode_q, step_mode_d;
   logic             halt_pend_q, halt_pend_d;
   logic             resume_q, resume_d;
   logic             bp_hit_q, bp_hit_d;
   logic             bus_err_q, bus_err_d;
   logic [WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [WIDTH-1:0] ins_cnt_q, ins_cnt_d;

   logic mem_wait_eff, bp_block, waiting_phase, timeout;

   always_comb begin
      st_f     = (state_q == S_F);
      st_e     = (state_q == S_E);
      st_m     = (state_q == S_M);
      st_w     = (state_q == S_W);
      halted   = (state_q == S_HALT);
      clk_stat = state_q;

      mem_wait_eff  = mem_wait & (wait_cnt_q != WMAX);
      bp_block      = bp_en & (pc == bp_addr) & ~resume_q;
      waiting_phase = (st_f & ~bp_block) | st_m;
      timeout       = waiting_phase & mem_wait & (wait_cnt_q == WMAX);

      // Strobes are suppressed while reset is held so an aborted phase enables nothing.
      phf = st_f & ~mem_wait_eff & ~bp_block & ~reset;
      phe = st_e & ~reset;
      phm = st_m & ~mem_wait_eff & ~reset;
      phw = st_w & ~reset;

      state_d     = state_q;
      step_mode_d = step_mode_q;
      resume_d    = resume_q;
      bp_hit_d    = bp_hit_q;
      bus_err_d   = bus_err_q | timeout;
      halt_pend_d = halt_pend_q | (halt_req & ~halted);
      wait_cnt_d  = (waiting_phase & mem_wait_eff) ? wait_cnt_q + CW'(1) : '0;

      case (state_q)
         S_HALT: begin
            if (step_req | run_en) begin
               state_d     = S_F;
               step_mode_d = step_req;
               resume_d    = 1'b1;
               bp_hit_d    = 1'b0;
               bus_err_d   = 1'b0;
            end
         end
         S_F: begin
            if (bp_block) begin
               state_d  = S_HALT;
               bp_hit_d = 1'b1;
            end else if (phf) begin
               state_d  = S_E;
               resume_d = 1'b0;
            end
         end
         S_E: state_d = S_M;
         S_M: if (phm) state_d = S_W;
         S_W: begin
            if (halt_pend_q | halt_req | step_mode_q | bus_err_q | ~run_en)
               state_d = S_HALT;
            else
               state_d = S_F;
         end
         default: state_d = S_HALT;
      endcase

      if (state_d == S_HALT && !halted) halt_pend_d = 1'b0;

      cyc_cnt_d = cyc_cnt_q + {{(WIDTH-1){1'b0}}, ~halted};
      ins_cnt_d = ins_cnt_q + {{(WIDTH-1){1'b0}}, phw};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= (START_RUN != 0) ? S_F : S_HALT;
         wait_cnt_q  <= '0;
         step_mode_q <= 1'b0;
         halt_pend_q <= 1'b0;
         resume_q    <= 1'b0;
         bp_hit_q    <= 1'b0;
         bus_err_q   <= 1'b0;
         cyc_cnt_q   <= '0;
         ins_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         step_mode_q <= step_mode_d;
         halt_pend_q <= halt_pend_d;
         resume_q    <= resume_d;
         bp_hit_q    <= bp_hit_d;
         bus_err_q   <= bus_err_d;
         cyc_cnt_q   <= cyc_cnt_d;
         ins_cnt_q   <= ins_cnt_d;
      end
   end

   assign bp_hit  = bp_hit_q;
   assign bus_err = bus_err_q;
   assign cyc_cnt = cyc_cnt_q;
   assign ins_cnt = ins_cnt_q;

endmodule

// File: tb/tb_cpu_phase_ctl.sv
// Directed bench for cpu_phase_ctl: per-cycle vector table plus hand sequences
// for wait timeout and reset in the middle of a stretched M phase.
module tb_cpu_phase_ctl;
   logic        clk = 1'b0;
   logic        reset, run_en, step_req, halt_req, mem_wait, bp_en;
   logic [31:0] bp_addr, pc;
   logic        st_f, st_e, st_m, st_w, phf, phe, phm, phw;
   logic        halted, bp_hit, bus_err;
   logic [2:0]  clk_stat;
   logic [31:0] cyc_cnt, ins_cnt;

   int n_vec = 0;
   int n_err = 0;

   cpu_phase_ctl #(.WIDTH(32), .WAIT_MAX(15), .START_RUN(1)) dut (
      .clk(clk), .reset(reset), .run_en(run_en), .step_req(step_req),
      .halt_req(halt_req), .mem_wait(mem_wait), .bp_en(bp_en),
      .bp_addr(bp_addr), .pc(pc),
      .st_f(st_f), .st_e(st_e), .st_m(st_m), .st_w(st_w),
      .phf(phf), .phe(phe), .phm(phm), .phw(phw),
      .halted(halted), .bp_hit(bp_hit), .bus_err(bus_err),
      .clk_stat(clk_stat), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        run_en, step_req, halt_req, mem_wait, bp_en;
      logic [31:0] pc;
      logic [2:0]  stat;
      logic [3:0]  ph;     // {phf, phe, phm, phw}
      logic        bp_hit, bus_err;
   } vec_t;

   vec_t vt[$];

   task automatic v(input logic r, input logic s, input logic h, input logic mw,
                    input logic be, input logic [31:0] p, input logic [2:0] st,
                    input logic [3:0] ph, input logic bh, input logic berr);
      vec_t x;
      x.run_en = r; x.step_req = s; x.halt_req = h; x.mem_wait = mw; x.bp_en = be;
      x.pc = p; x.stat = st; x.ph = ph; x.bp_hit = bh; x.bus_err = berr;
      vt.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [13:0] exp_word(input vec_t x);
      logic [3:0] st;
      st = {x.stat == 3'd1, x.stat == 3'd2, x.stat == 3'd3, x.stat == 3'd4};
      return {x.stat, x.ph, st, x.stat == 3'd0, x.bp_hit, x.bus_err};
   endfunction

   function automatic logic [13:0] act_word();
      return {clk_stat, phf, phe, phm, phw, st_f, st_e, st_m, st_w, halted, bp_hit, bus_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nophf_bad;
      reset = 1'b1; run_en = 1'b1; step_req = 1'b0; halt_req = 1'b0;
      mem_wait = 1'b0; bp_en = 1'b0; bp_addr = 32'h10; pc = 32'h0;

      // reset state, strobes held low during reset
      tick(); tick();
      chk("reset_outputs", {50'd0, act_word()}, {50'd0, 3'd1, 4'b0000, 4'b1000, 3'b000});
      chk("reset_cyc", cyc_cnt, 0);
      chk("reset_ins", ins_cnt, 0);
      reset = 1'b0;

      // free run
      repeat (40) tick();
      chk("run40_ins", ins_cnt, 10);
      chk("run40_cyc", cyc_cnt, 40);

      // wait states in M
      v(1,0,0,0,0,32'h00, 1,4'b1000,0,0);
      v(1,0,0,0,0,32'h00, 2,4'b0100,0,0);
      v(1,0,0,1,0,32'h00, 3,4'b0000,0,0);
      v(1,0,0,1,0,32'h00, 3,4'b0000,0,0);
      v(1,0,0,1,0,32'h00, 3,4'b0000,0,0);
      v(1,0,0,0,0,32'h00, 3,4'b0010,0,0);
      v(1,0,0,0,0,32'h00, 4,4'b0001,0,0);
      // halt_req in E, resume on run_en
      v(1,0,0,0,0,32'h00, 1,4'b1000,0,0);
      v(1,0,1,0,0,32'h00, 2,4'b0100,0,0);
      v(1,0,0,0,0,32'h00, 3,4'b0010,0,0);
      v(1,0,0,0,0,32'h00, 4,4'b0001,0,0);
      v(0,0,0,0,0,32'h00, 0,4'b0000,0,0);
      v(0,0,0,0,0,32'h00, 0,4'b0000,0,0);
      v(1,0,0,0,0,32'h00, 0,4'b0000,0,0);
      v(1,0,0,0,0,32'h00, 1,4'b1000,0,0);
      v(1,0,0,0,0,32'h00, 2,4'b0100,0,0);
      v(1,0,0,0,0,32'h00, 3,4'b0010,0,0);
      v(0,0,0,0,0,32'h00, 4,4'b0001,0,0);
      v(0,0,0,0,0,32'h00, 0,4'b0000,0,0);
      // step with simultaneous halt_req
      v(0,1,1,0,0,32'h00, 0,4'b0000,0,0);
      v(0,0,0,0,0,32'h00, 1,4'b1000,0,0);
      v(0,0,0,0,0,32'h00, 2,4'b0100,0,0);
      v(0,0,0,0,0,32'h00, 3,4'b0010,0,0);
      v(0,0,0,0,0,32'h00, 4,4'b0001,0,0);
      v(0,0,0,0,0,32'h00, 0,4'b0000,0,0);
      // breakpoint at 0x10, then single-step across it
      v(1,0,0,0,1,32'h0C, 0,4'b0000,0,0);
      v(1,0,0,0,1,32'h0C, 1,4'b1000,0,0);
      v(1,0,0,0,1,32'h10, 2,4'b0100,0,0);
      v(1,0,0,0,1,32'h10, 3,4'b0010,0,0);
      v(1,0,0,0,1,32'h10, 4,4'b0001,0,0);
      v(0,0,0,0,1,32'h10, 1,4'b0000,0,0);
      v(0,0,0,0,1,32'h10, 0,4'b0000,1,0);
      v(0,1,0,0,1,32'h10, 0,4'b0000,1,0);
      v(0,0,0,0,1,32'h10, 1,4'b1000,0,0);
      v(0,0,0,0,1,32'h14, 2,4'b0100,0,0);
      v(0,0,0,0,1,32'h14, 3,4'b0010,0,0);
      v(0,0,0,0,1,32'h14, 4,4'b0001,0,0);
      v(0,0,0,0,1,32'h14, 0,4'b0000,0,0);

      foreach (vt[i]) begin
         run_en = vt[i].run_en; step_req = vt[i].step_req; halt_req = vt[i].halt_req;
         mem_wait = vt[i].mem_wait; bp_en = vt[i].bp_en; pc = vt[i].pc;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {50'd0, act_word()}, {50'd0, exp_word(vt[i])});
         tick();
      end
      step_req = 1'b0; halt_req = 1'b0; bp_en = 1'b0; pc = 32'h0;
      chk("table_ins", ins_cnt, 16);
      chk("table_cyc", cyc_cnt, 68);

      // wait timeout in F
      run_en = 1'b1; mem_wait = 1'b1;
      tick();
      nophf_bad = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (phf || !st_f) nophf_bad++;
         tick();
      end
      chk("t3_wait_no_phf", nophf_bad, 0);
      @(negedge clk);
      chk("t3_forced_phf", {st_f, phf}, 2'b11);
      tick();
      run_en = 1'b0; mem_wait = 1'b0;
      chk("t3_bus_err_E", {clk_stat, bus_err}, {3'd2, 1'b1});
      tick(); tick(); tick();
      chk("t3_halt_after_w", {clk_stat, halted, bus_err}, {3'd0, 1'b1, 1'b1});
      run_en = 1'b1;
      tick();
      chk("t3_clear_on_leave", {clk_stat, bus_err}, {3'd1, 1'b0});

      // reset during a stretched M
      tick(); tick();
      mem_wait = 1'b1;
      @(negedge clk);
      chk("t6_in_m_wait", {st_m, phm}, 2'b10);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_no_phm_in_reset", phm, 0);
      tick();
      chk("t6_state_after", {clk_stat, halted}, {3'd1, 1'b0});
      chk("t6_cnts", {cyc_cnt, ins_cnt}, 64'd0);
      reset = 1'b0; mem_wait = 1'b0;
      @(negedge clk);
      chk("t6_restart_phf", phf, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
